// File: rtl/dac_pkg.sv
// Shared widths, full-scale code, sequencer states and thermometer decode for the DAC segment encoder.
package dac_pkg;

  localparam int unsigned NBIN   = 8;
  localparam int unsigned NTHERM = 17;
  localparam int unsigned CODE_W = 13;
  localparam int unsigned FS     = NTHERM * (2 ** NBIN) + (2 ** NBIN) - 1;
  localparam int unsigned M_W    = $clog2(NTHERM + 1);
  localparam int unsigned PTR_W  = $clog2(NTHERM);
  localparam int unsigned SPAN_W = NTHERM + 1;

  typedef enum logic [1:0] {
    OFF,
    WAKE,
    RUN,
    DRAIN
  } enc_state_e;

  // Stage1 payload: clipped code plus its saturation flag.
  typedef struct packed {
    logic              sat;
    logic [CODE_W-1:0] code;
  } s1_t;

  // Low-aligned thermometer: m ones starting at bit 0 (m=NTHERM gives all ones).
  function automatic logic [NTHERM-1:0] therm_decode(input logic [M_W-1:0] m);
    logic [SPAN_W-1:0] span;
    span = SPAN_W'(1) << m;
    return NTHERM'(span - SPAN_W'(1));
  endfunction

endpackage

// File: rtl/dac_therm_rotator.sv
// Rotational DEM for the thermometer field: pointer register plus barrel rotate of the decoded mask.
module dac_therm_rotator
  import dac_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [M_W-1:0]    m_i,
  output logic [NTHERM-1:0] therm_c_o
);

  localparam int unsigned SUM_W = PTR_W + 1;

  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [SUM_W-1:0]    sum;
  logic [NTHERM-1:0]   base;
  logic [2*NTHERM-1:0] dbl;

  // Pointer advances by m modulo NTHERM on each encoded code; m=NTHERM wraps back to itself.
  always_comb begin
    ptr_d = ptr_q;
    sum   = SUM_W'(ptr_q) + SUM_W'(m_i);
    if (load_i) begin
      if (sum >= SUM_W'(NTHERM)) ptr_d = PTR_W'(sum - SUM_W'(NTHERM));
      else                       ptr_d = PTR_W'(sum);
    end
  end

  // Rotate left by the pointer; bits shifted past the top wrap into the low half.
  always_comb begin
    base      = therm_decode(m_i);
    dbl       = {NTHERM'(0), base} << ptr_q;
    therm_c_o = dbl[NTHERM-1:0] | dbl[2*NTHERM-1:NTHERM];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dac_segment_encoder.sv
// Code-to-segment encoder with power sequencer and 2-stage pipeline feeding driver_cell.
// Define DAC_DEM_EN to enable rotational element matching on the thermometer field.
module dac_segment_encoder
  import dac_pkg::*;
#(
  parameter int unsigned WAKE_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              s_valid,
  input  logic [CODE_W-1:0] s_code,
  output logic              s_ready,
  output logic [NBIN-1:0]   datain,
  output logic [NBIN-1:0]   datainb,
  output logic [NTHERM-1:0] datatherm,
  output logic [NTHERM-1:0] datathermb,
  output logic              pdb,
  output logic              sat,
  output logic              busy
);

  localparam int unsigned     CNT_W      = $clog2(WAKE_CYC + 3);
  localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_ZERO = CNT_W'(2);

  enc_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  s1_t               s1_q, s1_d;
  logic              s1_vld_q, s1_vld_d;
  logic              ready_q, ready_d;
  logic              pdb_q, pdb_d;
  logic              busy_q, busy_d;
  logic              sat_q, sat_d;
  logic [NBIN-1:0]   din_q, din_d, dinb_q;
  logic [NTHERM-1:0] therm_q, therm_d, thermb_q;

  logic              xfer;
  logic              zero_code;
  logic              load;
  logic [M_W-1:0]    s1_m;
  logic [NTHERM-1:0] therm_next;

  assign xfer = s_valid && ready_q;
  assign s1_m = M_W'(s1_q.code >> NBIN);

  // Sequencer next state: WAKE counts settling cycles, DRAIN empties the pipe then drives one zero cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      OFF: begin
        if (en) begin
          state_d = WAKE;
          cnt_d   = '0;
        end
      end
      WAKE: begin
        if (!en) begin
          state_d = OFF;
          cnt_d   = '0;
        end else if (cnt_q == WAKE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!en) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_ZERO) begin
          state_d = OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Stage1: clip to full scale and flag saturation.
  always_comb begin
    s1_d     = s1_q;
    s1_vld_d = xfer;
    if (xfer) begin
      s1_d.sat  = (s_code > CODE_W'(FS));
      s1_d.code = s1_d.sat ? CODE_W'(FS) : s_code;
    end
  end

`ifdef DAC_DEM_EN
  dac_therm_rotator u_rot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .m_i       (s1_m),
    .therm_c_o (therm_next)
  );
`else
  assign therm_next = therm_decode(s1_m);
`endif

  // Stage2: encode, or force the zero code while waking, off, or in the final drain cycle.
  always_comb begin
    zero_code = (state_d == OFF) || (state_d == WAKE) ||
                ((state_d == DRAIN) && (cnt_d == DRAIN_ZERO));
    load      = s1_vld_q && !zero_code;
    din_d     = din_q;
    therm_d   = therm_q;
    sat_d     = sat_q;
    if (zero_code) begin
      din_d   = '0;
      therm_d = '0;
      sat_d   = 1'b0;
    end else if (load) begin
      din_d   = s1_q.code[NBIN-1:0];
      therm_d = therm_next;
      sat_d   = s1_q.sat;
    end
    pdb_d   = (state_d != OFF);
    busy_d  = (state_d != OFF);
    ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OFF;
      cnt_q    <= '0;
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      ready_q  <= 1'b0;
      pdb_q    <= 1'b0;
      busy_q   <= 1'b0;
      sat_q    <= 1'b0;
      din_q    <= '0;
      dinb_q   <= '1;
      therm_q  <= '0;
      thermb_q <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s1_q     <= s1_d;
      s1_vld_q <= s1_vld_d;
      ready_q  <= ready_d;
      pdb_q    <= pdb_d;
      busy_q   <= busy_d;
      sat_q    <= sat_d;
      din_q    <= din_d;
      dinb_q   <= ~din_d;
      therm_q  <= therm_d;
      thermb_q <= ~therm_d;
    end
  end

  assign s_ready    = ready_q;
  assign datain     = din_q;
  assign datainb    = dinb_q;
  assign datatherm  = therm_q;
  assign datathermb = thermb_q;
  assign pdb        = pdb_q;
  assign sat        = sat_q;
  assign busy       = busy_q;

endmodule
